// File: rtl/game_state_ctrl.sv
// Game flow controller: IDLE -> READY -> PLAY -> OVER, with BCD score,
// high score tracking, object-clear pulse and attract-mode blink.
module game_state_ctrl #(
    parameter int unsigned READY_TICKS     = 60,
    parameter int unsigned OVER_HOLD_TICKS = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start,
    input  logic        hit,
    input  logic        pipe_pass,
    output logic [1:0]  state,
    output logic        run,
    output logic        clear_obj,
    output logic [15:0] score,
    output logic [15:0] hiscore,
    output logic        game_over,
    output logic        blink
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [9:0] READY_LAST = 10'(READY_TICKS - 1);
    localparam logic [9:0] HOLD_LAST  = 10'(OVER_HOLD_TICKS);

    state_t      cur, nxt;
    logic        start_q;
    logic        start_rise;
    logic        go_ready;
    logic [9:0]  cnt;
    logic [4:0]  blink_cnt;
    logic [15:0] score_nxt;

    // Saturating 4-digit BCD increment: 9999 stays 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (carry) begin
                    if (v[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign start_rise = start & ~start_q;

    // Next-state decode; go_ready marks every entry into READY.
    always_comb begin
        nxt      = cur;
        go_ready = 1'b0;
        case (cur)
            IDLE: begin
                if (start_rise) begin
                    nxt      = READY;
                    go_ready = 1'b1;
                end
            end
            READY: begin
                if (tick && cnt == READY_LAST) nxt = PLAY;
            end
            PLAY: begin
                if (hit) nxt = OVER;
            end
            OVER: begin
                if (start_rise && cnt == HOLD_LAST) begin
                    nxt      = READY;
                    go_ready = 1'b1;
                end
            end
        endcase
    end

    // Score after this clk: cleared on a new game, bumped by pipe_pass in PLAY.
    always_comb begin
        score_nxt = score;
        if (go_ready) begin
            score_nxt = '0;
        end else if (cur == PLAY && pipe_pass) begin
            score_nxt = bcd_inc(score);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) cur <= IDLE;
        else       cur <= nxt;
    end

    // Registered outputs, counters and start edge detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q   <= 1'b1;
            score     <= '0;
            hiscore   <= '0;
            clear_obj <= 1'b0;
            run       <= 1'b0;
            game_over <= 1'b0;
            cnt       <= '0;
            blink_cnt <= '0;
        end else begin
            start_q   <= start;
            score     <= score_nxt;
            clear_obj <= go_ready;
            run       <= (nxt == PLAY);
            game_over <= (nxt == OVER);
            // Compare against the post-increment score so a same-clk pipe_pass counts.
            if (cur == PLAY && nxt == OVER && score_nxt > hiscore) hiscore <= score_nxt;

            if (nxt != cur) begin
                cnt <= '0;
            end else if (tick) begin
                if (cur == READY) cnt <= cnt + 10'd1;
                else if (cur == OVER && cnt < HOLD_LAST) cnt <= cnt + 10'd1;
            end

            if (nxt != cur) begin
                blink_cnt <= '0;
            end else if (tick && (cur == IDLE || cur == OVER)) begin
                blink_cnt <= blink_cnt + 5'd1;
            end
        end
    end

    assign state = cur;
    assign blink = blink_cnt[4];

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: stimulus pushes expected snapshots,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_game_state_ctrl;

    logic        clk = 1'b0;
    logic        reset, tick, start, hit, pipe_pass;
    logic [1:0]  state;
    logic        run, clear_obj, game_over, blink;
    logic [15:0] score, hiscore;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [1:0]  st;
        logic        clr;
        logic [15:0] sc;
        logic [15:0] hs;
        logic        chkb;
        logic        bl;
    } exp_t;

    exp_t sb[$];

    game_state_ctrl #(.READY_TICKS(4), .OVER_HOLD_TICKS(8)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .hit(hit),
        .pipe_pass(pipe_pass), .state(state), .run(run), .clear_obj(clear_obj),
        .score(score), .hiscore(hiscore), .game_over(game_over), .blink(blink)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, string field, logic [15:0] got, logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s got %h want %h", name, field, got, want);
        end
    endfunction

    // Monitor: one expected snapshot consumed per falling edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "state",     {14'd0, state},     {14'd0, e.st});
            chk(e.name, "run",       {15'd0, run},       {15'd0, e.st == 2'd2});
            chk(e.name, "game_over", {15'd0, game_over}, {15'd0, e.st == 2'd3});
            chk(e.name, "clear_obj", {15'd0, clear_obj}, {15'd0, e.clr});
            chk(e.name, "score",     score,              e.sc);
            chk(e.name, "hiscore",   hiscore,            e.hs);
            if (e.chkb) chk(e.name, "blink", {15'd0, blink}, {15'd0, e.bl});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_(string name, logic [1:0] st, logic clr, logic [15:0] sc,
                           logic [15:0] hs, logic chkb, logic bl);
        exp_t e;
        e.name = name; e.st = st; e.clr = clr; e.sc = sc; e.hs = hs; e.chkb = chkb; e.bl = bl;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic do_tick(int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; cyc(); tick = 1'b0; cyc();
        end
    endtask

    task automatic do_pass(int n);
        for (int i = 0; i < n; i++) begin
            pipe_pass = 1'b1; cyc(); pipe_pass = 1'b0; cyc();
        end
    endtask

    task automatic press();
        start = 1'b1; cyc(); start = 1'b0; cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b1; tick = 1'b0; hit = 1'b0; pipe_pass = 1'b0;
        cyc();
        expect_("reset", 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        cyc(); reset = 1'b0; cyc(); cyc();
        expect_("held_start_idle", 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        start = 1'b0; cyc();

        do_tick(16);
        expect_("idle_blink", 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);

        start = 1'b1; cyc();
        expect_("start_clr", 2'd1, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0);
        cyc();
        expect_("clr_once", 2'd1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        cyc(); start = 1'b0;

        hit = 1'b1; cyc(); hit = 1'b0;
        pipe_pass = 1'b1; cyc(); pipe_pass = 1'b0; cyc();
        expect_("ready_ignores", 2'd1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        do_tick(3);
        expect_("ready_3ticks", 2'd1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        do_tick(1);
        expect_("play_entry", 2'd2, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

        do_pass(12);
        expect_("score12", 2'd2, 1'b0, 16'h0012, 16'h0000, 1'b0, 1'b0);
        hit = 1'b1; cyc(); hit = 1'b0;
        expect_("over12", 2'd3, 1'b0, 16'h0012, 16'h0012, 1'b1, 1'b0);

        do_tick(3);
        pipe_pass = 1'b1; cyc(); pipe_pass = 1'b0;
        start = 1'b1; cyc();
        expect_("early_start", 2'd3, 1'b0, 16'h0012, 16'h0012, 1'b0, 1'b0);
        do_tick(5);
        expect_("held_start_over", 2'd3, 1'b0, 16'h0012, 16'h0012, 1'b0, 1'b0);
        start = 1'b0; cyc(); start = 1'b1; cyc();
        expect_("restart", 2'd1, 1'b1, 16'h0000, 16'h0012, 1'b0, 1'b0);
        start = 1'b0;

        do_tick(4);
        do_pass(5);
        pipe_pass = 1'b1; hit = 1'b1; cyc(); pipe_pass = 1'b0; hit = 1'b0;
        expect_("lower_game", 2'd3, 1'b0, 16'h0006, 16'h0012, 1'b0, 1'b0);

        do_tick(8); press(); do_tick(4);
        do_pass(7);
        expect_("pre_reset", 2'd2, 1'b0, 16'h0007, 16'h0012, 1'b0, 1'b0);
        reset = 1'b1; start = 1'b1; cyc();
        expect_("reset_in_play", 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        cyc(); reset = 1'b0; cyc(); cyc();
        expect_("held_through_reset", 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        start = 1'b0; cyc();

        press(); do_tick(4); do_pass(5);
        pipe_pass = 1'b1; hit = 1'b1; cyc(); pipe_pass = 1'b0; hit = 1'b0;
        expect_("same_cycle", 2'd3, 1'b0, 16'h0006, 16'h0006, 1'b0, 1'b0);

        do_tick(8); press();
        expect_("new_game", 2'd1, 1'b0, 16'h0000, 16'h0006, 1'b0, 1'b0);
        do_tick(4);
        do_pass(999);
        expect_("score0999", 2'd2, 1'b0, 16'h0999, 16'h0006, 1'b0, 1'b0);
        do_pass(1);
        expect_("score1000", 2'd2, 1'b0, 16'h1000, 16'h0006, 1'b0, 1'b0);
        do_pass(8999);
        expect_("score9999", 2'd2, 1'b0, 16'h9999, 16'h0006, 1'b0, 1'b0);
        do_pass(1);
        expect_("saturate", 2'd2, 1'b0, 16'h9999, 16'h0006, 1'b0, 1'b0);
        hit = 1'b1; cyc(); hit = 1'b0;
        expect_("hiscore9999", 2'd3, 1'b0, 16'h9999, 16'h9999, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
